// File: rtl/neuron_learn_layer_seq.sv
// neuron_learn_layer_seq: M learning neurons share one captured N-lane input vector.
// The block has valid/ready handshakes on both sides and registered forward outputs.
// The per-neuron back-propagated expected_in vectors are averaged one neuron per
// cycle through a single bank of N accumulators, so no M-input adder tree is needed.
// neuron_learn is the compact learning neuron that the layer instantiates.
// neuron m drives its output from input lane (m % N). Its back-propagated target for
// lane j is the midpoint of in[j] and its own training target.

module neuron_learn #(
    parameter int N    = 16,
    parameter int ZW   = 16,
    parameter int FW   = 16,
    parameter int LANE = 0
) (
    input  logic                 clock_i,
    input  logic                 valid_i,
    input  logic                 learn_i,
    input  logic [ZW-1:0]        in_i [N],
    input  logic [ZW-1:0]        expected_out_i,
    output logic [ZW-1:0]        out_o,
    output logic [ZW-1:0]        expected_in_o [N],
    output logic signed [FW-1:0] weights_o [N],
    output logic signed [FW-1:0] activation_max_o,
    output logic signed [FW-1:0] activation_min_o
);

    logic [ZW-1:0]        x_q [N];
    logic [ZW-1:0]        t_q;
    logic signed [FW-1:0] w_q [N];
    logic signed [FW-1:0] amax_q;
    logic signed [FW-1:0] amin_q;
    logic signed [FW-1:0] act_s;
    logic [ZW:0]          mid_s [N];

    // One saturating +/-1 step of a weight toward the training target.
    function automatic logic signed [FW-1:0] step_weight(
        input logic signed [FW-1:0] w,
        input logic [ZW-1:0]        x,
        input logic [ZW-1:0]        t
    );
        logic signed [FW:0] s;
        s = {w[FW-1], w};
        if (t > x) begin
            s = s + {{FW{1'b0}}, 1'b1};
        end else if (t < x) begin
            s = s - {{FW{1'b0}}, 1'b1};
        end else begin
            s = s;
        end
        if (s[FW] != s[FW-1]) begin
            step_weight = s[FW] ? {1'b1, {(FW-1){1'b0}}} : {1'b0, {(FW-1){1'b1}}};
        end else begin
            step_weight = s[FW-1:0];
        end
    endfunction

    assign act_s = FW'({1'b0, in_i[LANE][ZW-1:1]});

    // On a fire: capture the operands, then adapt the weights and the activation range.
    // Training state is owned by the neuron and is deliberately not cleared by reset.
    always_ff @(posedge clock_i) begin
        if (valid_i) begin
            x_q    <= in_i;
            t_q    <= expected_out_i;
            amax_q <= (act_s > amax_q) ? act_s : amax_q;
            amin_q <= (act_s < amin_q) ? act_s : amin_q;
            for (int j = 0; j < N; j++) begin
                if (learn_i) begin
                    w_q[j] <= step_weight(w_q[j], in_i[j], expected_out_i);
                end
            end
        end
    end

    assign out_o            = x_q[LANE];
    assign weights_o        = w_q;
    assign activation_max_o = amax_q;
    assign activation_min_o = amin_q;

    for (genvar j = 0; j < N; j++) begin : g_lane
        assign mid_s[j]         = {1'b0, x_q[j]} + {1'b0, t_q};
        assign expected_in_o[j] = mid_s[j][ZW:1];
    end

endmodule

module neuron_learn_layer_seq #(
    parameter int N          = 16,
    parameter int M          = 3,
    parameter int NEURON_LAT = 1,
    parameter int ZW         = 16,
    parameter int FW         = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 learn_i,
    input  logic [ZW-1:0]        in_i [N],
    input  logic [ZW-1:0]        expected_out_i [M],
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ZW-1:0]        out_o [M],
    output logic [ZW-1:0]        expected_in_o [N],
    output logic signed [FW-1:0] weights_o [M][N],
    output logic signed [FW-1:0] activation_max_o [M],
    output logic signed [FW-1:0] activation_min_o [M]
);

    // The accumulator carries clog2(M) extra bits, so a sum of M full-scale codes fits.
    localparam int ACCW = ZW + ((M > 1) ? $clog2(M) : 0);
    localparam int KW   = (M > 1) ? $clog2(M) : 1;
    localparam int LW   = (NEURON_LAT > 1) ? $clog2(NEURON_LAT) : 1;

    localparam logic [KW-1:0]   K_LAST   = KW'(M - 1);
    localparam logic [LW-1:0]   LAT_LOAD = LW'(NEURON_LAT - 1);
    localparam logic [ACCW-1:0] M_DIV    = ACCW'(M);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FIRE = 3'd1,
        S_WAIT = 3'd2,
        S_AVG  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [ZW-1:0]    in_q   [N];
    logic [ZW-1:0]    in_d   [N];
    logic [ZW-1:0]    eo_q   [M];
    logic [ZW-1:0]    eo_d   [M];
    logic             learn_q, learn_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [KW-1:0]    k_q, k_d;
    logic [ACCW-1:0]  acc_q  [N];
    logic [ACCW-1:0]  acc_d  [N];
    logic [ZW-1:0]    out_q  [M];
    logic [ZW-1:0]    out_d  [M];
    logic [ZW-1:0]    ein_q  [N];
    logic [ZW-1:0]    ein_d  [N];

    logic             fire_s;
    logic [ZW-1:0]    nout_s  [M];
    logic [ZW-1:0]    unavg_s [M][N];
    logic [ACCW-1:0]  sum_s   [N];

    // The neurons see exactly one valid pulse per accepted vector: the FIRE cycle.
    assign fire_s = (state_q == S_FIRE);

    for (genvar m = 0; m < M; m++) begin : g_neuron
        neuron_learn #(
            .N    (N),
            .ZW   (ZW),
            .FW   (FW),
            .LANE (m % N)
        ) u_neuron (
            .clock_i          (clock_i),
            .valid_i          (fire_s),
            .learn_i          (learn_q),
            .in_i             (in_q),
            .expected_out_i   (eo_q[m]),
            .out_o            (nout_s[m]),
            .expected_in_o    (unavg_s[m]),
            .weights_o        (weights_o[m]),
            .activation_max_o (activation_max_o[m]),
            .activation_min_o (activation_min_o[m])
        );
    end

    // Next-state and datapath: capture, fire, wait, sequential average, hand-off.
    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        eo_d    = eo_q;
        learn_d = learn_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        acc_d   = acc_q;
        out_d   = out_q;
        ein_d   = ein_q;
        for (int j = 0; j < N; j++) begin
            sum_s[j] = acc_q[j] + ACCW'(unavg_s[k_q][j]);
        end
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    in_d    = in_i;
                    eo_d    = expected_out_i;
                    learn_d = learn_i;
                    state_d = S_FIRE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FIRE: begin
                cnt_d   = LAT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    out_d = nout_s;
                    if (learn_q) begin
                        acc_d   = '{default: '0};
                        k_d     = '0;
                        state_d = S_AVG;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - LW'(1);
                end
            end
            S_AVG: begin
                acc_d = sum_s;
                if (k_q == K_LAST) begin
                    for (int j = 0; j < N; j++) begin
                        ein_d[j] = ZW'(sum_s[j] / M_DIV);
                    end
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any transaction in flight.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            in_q    <= '{default: '0};
            eo_q    <= '{default: '0};
            learn_q <= 1'b0;
            cnt_q   <= '0;
            k_q     <= '0;
            acc_q   <= '{default: '0};
            out_q   <= '{default: '0};
            ein_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            eo_q    <= eo_d;
            learn_q <= learn_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            ein_q   <= ein_d;
        end
    end

    assign in_ready_o    = (state_q == S_IDLE);
    assign out_valid_o   = (state_q == S_DONE);
    assign out_o         = out_q;
    assign expected_in_o = ein_q;

endmodule

// File: tb/tb_neuron_learn_layer_seq.sv
// Directed and reference-model bench for neuron_learn_layer_seq.
// Three instances: A (N=4, M=3, LAT=1) for the directed cases, B (N=1, M=1)
// and C (N=32, M=8, LAT=3) for the random parametric runs.

module tb_neuron_learn_layer_seq;

    localparam int ZW   = 16;
    localparam int FW   = 16;
    localparam int AN   = 4;
    localparam int AM   = 3;
    localparam int BN   = 1;
    localparam int BM   = 1;
    localparam int CN   = 32;
    localparam int CM   = 8;
    localparam int CLAT = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   fire_a, fire_b, fire_c;
    int   a_sent, b_sent, c_sent;

    logic                 a_in_valid, a_in_ready, a_learn, a_out_valid, a_out_ready;
    logic [ZW-1:0]        a_in [AN];
    logic [ZW-1:0]        a_eo [AM];
    logic [ZW-1:0]        a_out [AM];
    logic [ZW-1:0]        a_ein [AN];
    logic signed [FW-1:0] a_w [AM][AN];
    logic signed [FW-1:0] a_amax [AM];
    logic signed [FW-1:0] a_amin [AM];
    logic [ZW-1:0]        a_xout [AM];
    logic [ZW-1:0]        a_xein [AN];

    logic                 b_in_valid, b_in_ready, b_learn, b_out_valid, b_out_ready;
    logic [ZW-1:0]        b_in [BN];
    logic [ZW-1:0]        b_eo [BM];
    logic [ZW-1:0]        b_out [BM];
    logic [ZW-1:0]        b_ein [BN];
    logic signed [FW-1:0] b_w [BM][BN];
    logic signed [FW-1:0] b_amax [BM];
    logic signed [FW-1:0] b_amin [BM];
    logic [ZW-1:0]        b_xein;

    logic                 c_in_valid, c_in_ready, c_learn, c_out_valid, c_out_ready;
    logic [ZW-1:0]        c_in [CN];
    logic [ZW-1:0]        c_eo [CM];
    logic [ZW-1:0]        c_out [CM];
    logic [ZW-1:0]        c_ein [CN];
    logic signed [FW-1:0] c_w [CM][CN];
    logic signed [FW-1:0] c_amax [CM];
    logic signed [FW-1:0] c_amin [CM];
    logic [ZW-1:0]        c_xein [CN];

    neuron_learn_layer_seq #(.N(AN), .M(AM), .NEURON_LAT(1), .ZW(ZW), .FW(FW)) dut_a (
        .clock_i(clk), .reset_i(rst), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .learn_i(a_learn), .in_i(a_in), .expected_out_i(a_eo), .out_valid_o(a_out_valid),
        .out_ready_i(a_out_ready), .out_o(a_out), .expected_in_o(a_ein), .weights_o(a_w),
        .activation_max_o(a_amax), .activation_min_o(a_amin));

    neuron_learn_layer_seq #(.N(BN), .M(BM), .NEURON_LAT(1), .ZW(ZW), .FW(FW)) dut_b (
        .clock_i(clk), .reset_i(rst), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .learn_i(b_learn), .in_i(b_in), .expected_out_i(b_eo), .out_valid_o(b_out_valid),
        .out_ready_i(b_out_ready), .out_o(b_out), .expected_in_o(b_ein), .weights_o(b_w),
        .activation_max_o(b_amax), .activation_min_o(b_amin));

    neuron_learn_layer_seq #(.N(CN), .M(CM), .NEURON_LAT(CLAT), .ZW(ZW), .FW(FW)) dut_c (
        .clock_i(clk), .reset_i(rst), .in_valid_i(c_in_valid), .in_ready_o(c_in_ready),
        .learn_i(c_learn), .in_i(c_in), .expected_out_i(c_eo), .out_valid_o(c_out_valid),
        .out_ready_i(c_out_ready), .out_o(c_out), .expected_in_o(c_ein), .weights_o(c_w),
        .activation_max_o(c_amax), .activation_min_o(c_amin));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count neuron valid pulses per instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (dut_a.fire_s) fire_a++;
        if (dut_b.fire_s) fire_b++;
        if (dut_c.fire_s) fire_c++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic a_check_outputs(input string tag);
        for (int m = 0; m < AM; m++)
            check_eq($sformatf("%s out[%0d]", tag, m), 64'(a_out[m]), 64'(a_xout[m]));
        for (int j = 0; j < AN; j++)
            check_eq($sformatf("%s expected_in[%0d]", tag, j), 64'(a_ein[j]), 64'(a_xein[j]));
    endtask

    // Offer the current vector, scramble the inputs after acceptance, wait for out_valid.
    task automatic a_transact(input logic lrn, input int exp_cyc, input string tag);
        int cyc;
        check_eq({tag, " in_ready before"}, 64'(a_in_ready), 64'd1);
        a_learn    = lrn;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_sent++;
        a_in    = '{default: 16'h5A5A};
        a_eo    = '{default: 16'hA5A5};
        a_learn = ~lrn;
        cyc = 1;
        while (a_out_valid !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
    endtask

    task automatic a_release(input string tag);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        check_eq({tag, " out_valid after accept"}, 64'(a_out_valid), 64'd0);
        check_eq({tag, " in_ready after accept"}, 64'(a_in_ready), 64'd1);
    endtask

    initial begin
        int cyc;
        int sum;
        logic lrn;
        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_learn = 1'b0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_learn = 1'b0;
        c_in_valid = 1'b0; c_out_ready = 1'b0; c_learn = 1'b0;
        a_in = '{default: 16'd0}; a_eo = '{default: 16'd0};
        b_in = '{default: 16'd0}; b_eo = '{default: 16'd0};
        c_in = '{default: 16'd0}; c_eo = '{default: 16'd0};
        b_xein = 16'd0;
        c_xein = '{default: 16'd0};
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;

        // Reset state.
        check_eq("rst in_ready", 64'(a_in_ready), 64'd1);
        check_eq("rst out_valid", 64'(a_out_valid), 64'd0);
        check_eq("rst b in_ready", 64'(b_in_ready), 64'd1);
        check_eq("rst c out_valid", 64'(c_out_valid), 64'd0);
        a_xout = '{default: 16'd0};
        a_xein = '{default: 16'd0};
        a_check_outputs("rst");

        // Averaging: lane 0 back-propagated codes 100, 200, 300.
        a_in = '{16'd0, 16'd50, 16'd1000, 16'd65535};
        a_eo = '{16'd200, 16'd400, 16'd600};
        a_transact(1'b1, 6, "avg");
        a_xout = '{16'd0, 16'd50, 16'd1000};
        a_xein = '{16'd200, 16'd225, 16'd700, 16'd32967};
        a_check_outputs("avg");
        a_release("avg");

        // Forward only: expected_in keeps the previous average.
        a_in = '{16'd7, 16'd8, 16'd9, 16'd11};
        a_eo = '{16'd1, 16'd2, 16'd3};
        a_transact(1'b0, 3, "fwd");
        a_xout = '{16'd7, 16'd8, 16'd9};
        a_check_outputs("fwd");
        a_release("fwd");

        // Truncation: lane 0 codes 1, 1, 2 average to 1.
        a_in = '{16'd1, 16'd2, 16'd3, 16'd4};
        a_eo = '{16'd1, 16'd1, 16'd3};
        a_transact(1'b1, 6, "trunc");
        a_xout = '{16'd1, 16'd2, 16'd3};
        a_xein = '{16'd1, 16'd1, 16'd2, 16'd2};
        a_check_outputs("trunc");
        a_release("trunc");

        // Full-scale codes must average without overflow.
        a_in = '{default: 16'd65535};
        a_eo = '{default: 16'd65535};
        a_transact(1'b1, 6, "max");
        a_xout = '{default: 16'd65535};
        a_xein = '{default: 16'd65535};
        a_check_outputs("max");
        a_release("max");

        // Backpressure: hold DONE for 10 cycles while offering ignored vectors.
        a_in = '{16'd100, 16'd200, 16'd300, 16'd400};
        a_eo = '{16'd0, 16'd0, 16'd0};
        a_transact(1'b1, 6, "bp");
        a_xout = '{16'd100, 16'd200, 16'd300};
        a_xein = '{16'd50, 16'd100, 16'd150, 16'd200};
        for (int i = 0; i < 10; i++) begin
            a_in_valid = (i % 2 == 0);
            a_in = '{default: 16'd9};
            @(posedge clk); #1;
            check_eq($sformatf("bp hold %0d in_ready", i), 64'(a_in_ready), 64'd0);
            check_eq($sformatf("bp hold %0d out_valid", i), 64'(a_out_valid), 64'd1);
            a_check_outputs($sformatf("bp hold %0d", i));
        end
        a_in_valid = 1'b0;
        a_release("bp");
        check_eq("bp fire pulses", 64'(fire_a), 64'(a_sent));

        // Reset in the middle of AVG.
        a_in = '{16'd0, 16'd50, 16'd1000, 16'd65535};
        a_eo = '{16'd200, 16'd400, 16'd600};
        a_learn = 1'b1;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_sent++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst in_ready", 64'(a_in_ready), 64'd1);
        check_eq("midrst out_valid", 64'(a_out_valid), 64'd0);
        a_xout = '{default: 16'd0};
        a_xein = '{default: 16'd0};
        a_check_outputs("midrst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("midrst idle %0d out_valid", i), 64'(a_out_valid), 64'd0);
        end
        a_in = '{16'd0, 16'd50, 16'd1000, 16'd65535};
        a_eo = '{16'd200, 16'd400, 16'd600};
        a_transact(1'b1, 6, "after rst");
        a_xout = '{16'd0, 16'd50, 16'd1000};
        a_xein = '{16'd200, 16'd225, 16'd700, 16'd32967};
        a_check_outputs("after rst");
        a_release("after rst");
        check_eq("a fire pulses", 64'(fire_a), 64'(a_sent));

        // M=1, N=1: random vectors against the reference model.
        for (int v = 0; v < 1000; v++) begin
            b_in[0] = ZW'($urandom);
            b_eo[0] = ZW'($urandom);
            lrn = 1'($urandom_range(0, 1));
            b_learn = lrn;
            b_in_valid = 1'b1;
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            b_sent++;
            cyc = 1;
            while (b_out_valid !== 1'b1 && cyc < 64) begin
                @(posedge clk); #1;
                cyc++;
            end
            check_eq($sformatf("b latency v%0d", v), 64'(cyc), lrn ? 64'd4 : 64'd3);
            if (lrn) b_xein = ZW'((int'(b_in[0]) + int'(b_eo[0])) / 2);
            check_eq($sformatf("b out v%0d", v), 64'(b_out[0]), 64'(b_in[0]));
            check_eq($sformatf("b expected_in v%0d", v), 64'(b_ein[0]), 64'(b_xein));
            b_out_ready = 1'b1;
            @(posedge clk); #1;
            b_out_ready = 1'b0;
        end
        check_eq("b fire pulses", 64'(fire_b), 64'(b_sent));

        // M=8, N=32, NEURON_LAT=3: random vectors against the reference model.
        for (int v = 0; v < 1000; v++) begin
            for (int j = 0; j < CN; j++) c_in[j] = ZW'($urandom);
            for (int m = 0; m < CM; m++) c_eo[m] = ZW'($urandom);
            lrn = 1'($urandom_range(0, 1));
            c_learn = lrn;
            c_in_valid = 1'b1;
            @(posedge clk); #1;
            c_in_valid = 1'b0;
            c_sent++;
            cyc = 1;
            while (c_out_valid !== 1'b1 && cyc < 64) begin
                @(posedge clk); #1;
                cyc++;
            end
            check_eq($sformatf("c latency v%0d", v), 64'(cyc), lrn ? 64'(CLAT + CM + 2) : 64'(CLAT + 2));
            if (lrn) begin
                for (int j = 0; j < CN; j++) begin
                    sum = 0;
                    for (int m = 0; m < CM; m++) sum += (int'(c_in[j]) + int'(c_eo[m])) / 2;
                    c_xein[j] = ZW'(sum / CM);
                end
            end
            for (int m = 0; m < CM; m++)
                check_eq($sformatf("c out[%0d] v%0d", m, v), 64'(c_out[m]), 64'(c_in[m % CN]));
            for (int j = 0; j < CN; j++)
                check_eq($sformatf("c expected_in[%0d] v%0d", j, v), 64'(c_ein[j]), 64'(c_xein[j]));
            c_out_ready = 1'b1;
            @(posedge clk); #1;
            c_out_ready = 1'b0;
        end
        check_eq("c fire pulses", 64'(fire_c), 64'(c_sent));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
